// File: rtl/vga_sync_generator.sv
// Free-running VGA pixel timing: position, visible flag, syncs and strobes.
// Every output is registered from the same "next pixel" counters, so all outputs in a cycle describe one pixel.
module vga_sync_generator #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [9:0] o_hpos,
  output logic [9:0] o_vpos,
  output logic       o_visible,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_line_strobe,
  output logic       o_frame_strobe
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_STOP  = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_STOP  = VS_START + V_SYNC;
  localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_sync_generator: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic [9:0]  h_cnt_reg, h_cnt_next;
  logic [9:0]  v_cnt_reg, v_cnt_next;
  logic [10:0] h_ext, v_ext;
  logic        visible_next, hsync_next, vsync_next;
  logic        line_strobe_next, frame_strobe_next;

  always_comb begin
    h_cnt_next = h_cnt_reg + 10'd1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == 10'(H_TOTAL - 1)) begin
      h_cnt_next = '0;
      if (v_cnt_reg == 10'(V_TOTAL - 1)) begin
        v_cnt_next = '0;
      end else begin
        v_cnt_next = v_cnt_reg + 10'd1;
      end
    end
  end

  // One extra bit so a boundary equal to 1024 compares correctly.
  always_comb begin
    h_ext             = {1'b0, h_cnt_reg};
    v_ext             = {1'b0, v_cnt_reg};
    visible_next      = (h_ext < 11'(H_VISIBLE)) && (v_ext < 11'(V_VISIBLE));
    hsync_next        = ((h_ext >= 11'(HS_START)) && (h_ext < 11'(HS_STOP))) ? SYNC_ON : SYNC_OFF;
    vsync_next        = ((v_ext >= 11'(VS_START)) && (v_ext < 11'(VS_STOP))) ? SYNC_ON : SYNC_OFF;
    line_strobe_next  = (h_ext == 11'(H_VISIBLE));
    frame_strobe_next = (h_ext == 11'd0) && (v_ext == 11'(V_VISIBLE));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_reg      <= '0;
      v_cnt_reg      <= '0;
      o_hpos         <= '0;
      o_vpos         <= '0;
      o_visible      <= 1'b0;
      o_hsync        <= SYNC_OFF;
      o_vsync        <= SYNC_OFF;
      o_line_strobe  <= 1'b0;
      o_frame_strobe <= 1'b0;
    end else begin
      h_cnt_reg      <= h_cnt_next;
      v_cnt_reg      <= v_cnt_next;
      o_hpos         <= h_cnt_reg;
      o_vpos         <= v_cnt_reg;
      o_visible      <= visible_next;
      o_hsync        <= hsync_next;
      o_vsync        <= vsync_next;
      o_line_strobe  <= line_strobe_next;
      o_frame_strobe <= frame_strobe_next;
    end
  end

endmodule

// File: tb/tb_vga_sync_generator.sv
// Scoreboard bench: three configurations, expected pixels computed from the elapsed-cycle count.
module tb_vga_sync_generator;

  typedef struct packed {
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       vis;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } pix_t;

  typedef struct {
    int hv, hf, hsw, hb, vv, vf, vsw, vb;
    bit al;
  } cfg_t;

  logic       clk;
  logic       rst_n [3];
  logic [9:0] hpos [3];
  logic [9:0] vpos [3];
  logic       vis [3];
  logic       hs [3];
  logic       vs [3];
  logic       ls [3];
  logic       fs [3];

  int   checks = 0;
  int   errors = 0;
  cfg_t cfg [3];
  pix_t sb_q [3][$];
  int   pcnt [3];
  int   since_fs [3];
  int   ls_cnt [3];
  bit   fs_seen [3];

  vga_sync_generator u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .o_hpos(hpos[0]), .o_vpos(vpos[0]), .o_visible(vis[0]),
    .o_hsync(hs[0]), .o_vsync(vs[0]), .o_line_strobe(ls[0]), .o_frame_strobe(fs[0])
  );

  vga_sync_generator #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4), .SYNC_ACTIVE_LOW(1)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .o_hpos(hpos[1]), .o_vpos(vpos[1]), .o_visible(vis[1]),
    .o_hsync(hs[1]), .o_vsync(vs[1]), .o_line_strobe(ls[1]), .o_frame_strobe(fs[1])
  );

  vga_sync_generator #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE_LOW(0)
  ) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .o_hpos(hpos[2]), .o_vpos(vpos[2]), .o_visible(vis[2]),
    .o_hsync(hs[2]), .o_vsync(vs[2]), .o_line_strobe(ls[2]), .o_frame_strobe(fs[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int h_total(cfg_t c);
    return c.hv + c.hf + c.hsw + c.hb;
  endfunction

  function automatic int v_total(cfg_t c);
    return c.vv + c.vf + c.vsw + c.vb;
  endfunction

  function automatic pix_t reset_pix(cfg_t c);
    pix_t e;
    e    = '0;
    e.hs = c.al;
    e.vs = c.al;
    return e;
  endfunction

  // Pixel presented p cycles after the first post-reset edge.
  function automatic pix_t model(cfg_t c, int p);
    pix_t e;
    int   h, v;
    bit   hs_on, vs_on;
    h      = p % h_total(c);
    v      = (p / h_total(c)) % v_total(c);
    hs_on  = (h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hsw);
    vs_on  = (v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vsw);
    e.hpos = 10'(h);
    e.vpos = 10'(v);
    e.vis  = (h < c.hv) && (v < c.vv);
    e.hs   = c.al ? !hs_on : hs_on;
    e.vs   = c.al ? !vs_on : vs_on;
    e.ls   = (h == c.hv);
    e.fs   = (h == 0) && (v == c.vv);
    return e;
  endfunction

  function automatic pix_t sample(int i);
    return {hpos[i], vpos[i], vis[i], hs[i], vs[i], ls[i], fs[i]};
  endfunction

  task automatic check_pix(string name, int i, pix_t act, pix_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d got h=%0d v=%0d vis=%b hs=%b vs=%b ls=%b fs=%b want h=%0d v=%0d vis=%b hs=%b vs=%b ls=%b fs=%b",
               name, i, act.hpos, act.vpos, act.vis, act.hs, act.vs, act.ls, act.fs,
               req.hpos, req.vpos, req.vis, req.hs, req.vs, req.ls, req.fs);
    end
  endtask

  task automatic check_int(string name, int i, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s inst%0d got %0d want %0d", name, i, act, req);
    end
  endtask

  // Stimulus side of the scoreboard: each edge predicts what the DUT will present.
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst_n[i]) begin
          sb_q[i].push_back(model(cfg[i], pcnt[i]));
          pcnt[i]++;
        end else begin
          sb_q[i].push_back(reset_pix(cfg[i]));
          pcnt[i] = 0;
        end
      end
    end
  end

  // Monitor: pops one prediction per cycle; a reset held now overrides it.
  initial begin
    pix_t act, req;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        act = sample(i);
        if (sb_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty inst%0d got 0 entries want 1", i);
        end else begin
          req = sb_q[i].pop_front();
          if (!rst_n[i]) req = reset_pix(cfg[i]);
          check_pix("pixel", i, act, req);
        end
        if (!rst_n[i]) begin
          fs_seen[i] = 1'b0;
        end else begin
          since_fs[i]++;
          if (ls[i] === 1'b1) ls_cnt[i]++;
          if (fs[i] === 1'b1) begin
            if (fs_seen[i]) begin
              check_int("fs_period", i, since_fs[i], h_total(cfg[i]) * v_total(cfg[i]));
              check_int("ls_per_frame", i, ls_cnt[i], v_total(cfg[i]));
            end
            since_fs[i] = 0;
            ls_cnt[i]   = 0;
            fs_seen[i]  = 1'b1;
          end
        end
      end
    end
  end

  task automatic run_default();
    int n;
    bit found;
    n     = 0;
    found = 1'b0;
    while (!found && n < 20000) begin
      @(posedge clk);
      #1;
      if (hpos[0] == 10'd300 && vpos[0] == 10'd20) found = 1'b1;
      n++;
    end
    check_int("reach_300_20", 0, int'(found), 1);
    if (found) begin
      #1 rst_n[0] = 1'b0;
      #1 check_pix("async_rst", 0, sample(0), reset_pix(cfg[0]));
      repeat (3) @(posedge clk);
      #2 rst_n[0] = 1'b1;
      repeat (2000) @(posedge clk);
    end
  endtask

  task automatic run_random(int idx);
    int d;
    repeat (8) begin
      repeat ($urandom_range(150, 2500)) @(posedge clk);
      d = $urandom_range(1, 4);
      #(d) rst_n[idx] = 1'b0;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      d = $urandom_range(1, 4);
      #(d) rst_n[idx] = 1'b1;
    end
    repeat (700) @(posedge clk);
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1};
    cfg[1] = '{16, 4, 6, 4, 12, 3, 2, 4, 1'b1};
    cfg[2] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      rst_n[i]    = 1'b0;
      pcnt[i]     = 0;
      since_fs[i] = 0;
      ls_cnt[i]   = 0;
      fs_seen[i]  = 1'b0;
    end
    repeat (5) @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    fork
      run_default();
      run_random(1);
      run_random(2);
    join
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
